// File: rtl/bridge_bus_arbiter.sv
// rtl/bridge_bus_arbiter.sv - two-master round-robin arbiter and access sequencer for the system bridge
//
// Purpose: accepts one transaction at a time from m0 (CPU data) or m1 (DMA/debug),
// decodes it against the DM/TC0/TC1 windows, runs a fixed ADDR + WAIT access on the
// bridge and returns a one-cycle done/err/rdata response to the owning master.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   mX_req/addr/wdata/byteen   master request (req sampled only in IDLE; byteen 0 = read)
//   mX_ack                     one-cycle pulse in the ADDR cycle
//   mX_done/err/rdata          one-cycle response; err marks a rejected access
//   bus_addr/wdata/byteen      bridge-side drive, nonzero only during ADDR/WAIT
//   bus_rdata                  bridge read mux output
//   busy                       high in every state except IDLE
module bridge_bus_arbiter #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] DM_START    = 32'h0000_0000,
  parameter logic [31:0] DM_END      = 32'h0000_2FFF,
  parameter logic [31:0] TC0_START   = 32'h0000_7F00,
  parameter logic [31:0] TC0_END     = 32'h0000_7F0B,
  parameter logic [31:0] TC1_START   = 32'h0000_7F10,
  parameter logic [31:0] TC1_END     = 32'h0000_7F1B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_ack,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_ack,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} state_t;

  localparam logic [15:0] CNT_INIT = 16'(WAIT_CYCLES - 1);

  state_t      state;
  logic        owner;       // 1 = m1 owns the current transaction
  logic        last_grant;  // 1 = m1 was granted last
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_byteen;
  logic [15:0] cnt;

  logic        grant_m1;
  logic        any_req;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_byteen;
  logic        sel_ok;

  // Window test as a single unsigned subtraction: (a - lo) <= (hi - lo) covers
  // both inclusive bounds and avoids a constant compare when lo is zero.
  function automatic logic in_win(input logic [31:0] a, input logic [31:0] lo,
                                  input logic [31:0] hi);
    return (a - lo) <= (hi - lo);
  endfunction

  // m1 wins only if m0 is idle or m0 was served last.
  assign any_req    = m0_req | m1_req;
  assign grant_m1   = m1_req & (~m0_req | ~last_grant);
  assign sel_addr   = grant_m1 ? m1_addr   : m0_addr;
  assign sel_wdata  = grant_m1 ? m1_wdata  : m0_wdata;
  assign sel_byteen = grant_m1 ? m1_byteen : m0_byteen;

  // Timer windows only accept full-word or read accesses.
  assign sel_ok = in_win(sel_addr, DM_START, DM_END) ||
                  ((in_win(sel_addr, TC0_START, TC0_END) || in_win(sel_addr, TC1_START, TC1_END)) &&
                   (sel_byteen == 4'b0000 || sel_byteen == 4'b1111));

  // byteen is dropped after ADDR so each write lands exactly once.
  assign bus_addr   = (state == S_ADDR || state == S_WAIT) ? lat_addr  : 32'h0;
  assign bus_wdata  = (state == S_ADDR || state == S_WAIT) ? lat_wdata : 32'h0;
  assign bus_byteen = (state == S_ADDR) ? lat_byteen : 4'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_byteen <= 4'h0;
      cnt        <= 16'h0;
      busy       <= 1'b0;
      m0_ack     <= 1'b0;
      m0_done    <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= 32'h0;
      m1_ack     <= 1'b0;
      m1_done    <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= 32'h0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner      <= grant_m1;
            last_grant <= grant_m1;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            lat_byteen <= sel_byteen;
            busy       <= 1'b1;
            if (sel_ok) begin
              state <= S_ADDR;
              if (grant_m1) m1_ack <= 1'b1;
              else          m0_ack <= 1'b1;
            end else begin
              // Rejected: respond straight away, bus stays untouched.
              state <= S_RESP;
              if (grant_m1) begin
                m1_done <= 1'b1;
                m1_err  <= 1'b1;
              end else begin
                m0_done <= 1'b1;
                m0_err  <= 1'b1;
              end
            end
          end
        end
        S_ADDR: begin
          cnt   <= CNT_INIT;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 16'h0) begin
            state <= S_RESP;
            if (owner) begin
              m1_done  <= 1'b1;
              m1_rdata <= bus_rdata;
            end else begin
              m0_done  <= 1'b1;
              m0_rdata <= bus_rdata;
            end
          end else begin
            cnt <= cnt - 16'h1;
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          m0_done  <= 1'b0;
          m0_err   <= 1'b0;
          m0_rdata <= 32'h0;
          m1_done  <= 1'b0;
          m1_err   <= 1'b0;
          m1_rdata <= 32'h0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// tb/tb_bridge_bus_arbiter.sv - self-checking bench for bridge_bus_arbiter
module tb_bridge_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic [31:0] bus_rdata;

  logic        m0_ack, m0_done, m0_err, m1_ack, m1_done, m1_err, busy;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_byteen;

  logic        m0_ack_w3, m0_done_w3, m0_err_w3, m1_ack_w3, m1_done_w3, m1_err_w3, busy_w3;
  logic [31:0] m0_rdata_w3, m1_rdata_w3, bus_addr_w3, bus_wdata_w3;
  logic [3:0]  bus_byteen_w3;

  always #5 clk = ~clk;

  bridge_bus_arbiter u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m0_ack(m0_ack), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m1_ack(m1_ack), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
    .bus_rdata(bus_rdata), .busy(busy)
  );

  bridge_bus_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m0_ack(m0_ack_w3), .m0_done(m0_done_w3), .m0_err(m0_err_w3), .m0_rdata(m0_rdata_w3),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m1_ack(m1_ack_w3), .m1_done(m1_done_w3), .m1_err(m1_err_w3), .m1_rdata(m1_rdata_w3),
    .bus_addr(bus_addr_w3), .bus_wdata(bus_wdata_w3), .bus_byteen(bus_byteen_w3),
    .bus_rdata(bus_rdata), .busy(busy_w3)
  );

  typedef struct {
    logic        m;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic err, input logic [31:0] rdata,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    e.m = m; e.err = err; e.rdata = rdata; e.addr = addr; e.wdata = wdata; e.be = be;
    exp_q.push_back(e);
  endtask

  // Caller has driven the request; the next rising edge is the accept edge.
  task automatic run_txn(input int lat, input bit drop, input string tag);
    exp_t        e;
    int          n, ack_at, be_nz;
    logic        ack_m, got;
    logic [31:0] ack_addr, ack_wdata, wait_addr;
    logic [3:0]  ack_be;
    n = 0; ack_at = 0; be_nz = 0; got = 1'b0; ack_m = 1'b0;
    ack_addr = '0; ack_wdata = '0; ack_be = '0; wait_addr = '0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (drop && n == 1) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      if (bus_byteen != 4'h0) be_nz++;
      if ((m0_ack || m1_ack) && ack_at == 0) begin
        ack_at = n; ack_m = m1_ack;
        ack_addr = bus_addr; ack_wdata = bus_wdata; ack_be = bus_byteen;
      end
      if (n == 2) wait_addr = bus_addr;
      if (m0_done || m1_done) got = 1'b1;
    end
    chk({tag, ".got_done"}, 32'(got), 32'd1);
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    if (got && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".owner_done"}, 32'({m1_done, m0_done}), e.m ? 32'd2 : 32'd1);
      chk({tag, ".err"}, 32'(e.m ? m1_err : m0_err), 32'(e.err));
      chk({tag, ".rdata"}, e.m ? m1_rdata : m0_rdata, e.rdata);
      chk({tag, ".other_rdata"}, e.m ? m0_rdata : m1_rdata, 32'h0);
      chk({tag, ".resp_bus_addr"}, bus_addr, 32'h0);
      chk({tag, ".resp_busy"}, 32'(busy), 32'd1);
      if (!e.err) begin
        chk({tag, ".ack_cycle"}, 32'(ack_at), 32'd1);
        chk({tag, ".ack_owner"}, 32'(ack_m), 32'(e.m));
        chk({tag, ".addr"}, ack_addr, e.addr);
        chk({tag, ".wdata"}, ack_wdata, e.wdata);
        chk({tag, ".byteen"}, 32'(ack_be), 32'(e.be));
        chk({tag, ".wait_addr"}, wait_addr, e.addr);
        chk({tag, ".be_cycles"}, 32'(be_nz), (e.be != 4'h0) ? 32'd1 : 32'd0);
      end else begin
        chk({tag, ".no_ack"}, 32'(ack_at), 32'd0);
        chk({tag, ".no_bus"}, 32'(be_nz), 32'd0);
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_be"}, 32'(bus_byteen), 32'd0);
  endtask

  initial begin
    int          done_k;
    logic [31:0] done_rdata;
    exp_t        e3;
    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_byteen = '0; m1_byteen = '0; bus_rdata = '0;
    repeat (3) @(negedge clk);

    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'({m0_done, m1_done, m0_ack, m1_ack}), 32'd0);
    chk("rst.bus_addr", bus_addr, 32'h0);
    chk("rst.bus_byteen", 32'(bus_byteen), 32'd0);
    chk("rst.rdata", m0_rdata | m1_rdata, 32'h0);

    // DM read from m0 alone
    reset = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    m0_addr = 32'h0000_0010; m0_wdata = 32'h0; m0_byteen = 4'h0; m0_req = 1'b1;
    push(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h10, 32'h0, 4'h0);
    run_txn(3, 1'b1, "dm_read");
    idle_check("dm_read");

    // Both masters hold requests from reset: m0, m1, m0, m1
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus_rdata = 32'h0BAD_F00D;
    m0_addr = 32'h0000_0100; m0_wdata = 32'hAAAA_0001; m0_byteen = 4'hF; m0_req = 1'b1;
    m1_addr = 32'h0000_0204; m1_wdata = 32'h5555_0002; m1_byteen = 4'hF; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i[0]) push(1'b1, 1'b0, 32'h0BAD_F00D, 32'h204, 32'h5555_0002, 4'hF);
      else      push(1'b0, 1'b0, 32'h0BAD_F00D, 32'h100, 32'hAAAA_0001, 4'hF);
    end
    run_txn(3, 1'b0, "rr0"); idle_check("rr0");
    run_txn(3, 1'b0, "rr1"); idle_check("rr1");
    run_txn(3, 1'b0, "rr2"); idle_check("rr2");
    run_txn(3, 1'b1, "rr3"); idle_check("rr3");

    // Partial-byte timer write from m1 is rejected
    m1_addr = 32'h0000_7F04; m1_wdata = 32'h1234_5678; m1_byteen = 4'b0011; m1_req = 1'b1;
    push(1'b1, 1'b1, 32'h0, 32'h7F04, 32'h1234_5678, 4'b0011);
    run_txn(1, 1'b1, "tc_partial");
    idle_check("tc_partial");

    // Out-of-range read, then a valid TC1 read
    m0_addr = 32'h0000_5000; m0_wdata = 32'h0; m0_byteen = 4'h0; m0_req = 1'b1;
    push(1'b0, 1'b1, 32'h0, 32'h5000, 32'h0, 4'h0);
    run_txn(1, 1'b1, "oor");
    idle_check("oor");
    bus_rdata = 32'h0000_00A5;
    m0_addr = 32'h0000_7F14; m0_wdata = 32'h0000_0077; m0_byteen = 4'h0; m0_req = 1'b1;
    push(1'b0, 1'b0, 32'h0000_00A5, 32'h7F14, 32'h0000_0077, 4'h0);
    run_txn(3, 1'b1, "tc1_read");
    idle_check("tc1_read");

    // Reset during the WAIT cycle of an m1 write
    m1_addr = 32'h0000_0300; m1_wdata = 32'hCAFE_0003; m1_byteen = 4'hF; m1_req = 1'b1;
    @(negedge clk);
    chk("rst_mid.ack", 32'(m1_ack), 32'd1);
    m1_req = 1'b0;
    @(negedge clk);
    chk("rst_mid.wait_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.flags", 32'({m0_ack, m1_ack, m0_done, m1_done, m0_err, m1_err}), 32'd0);
    chk("rst_mid.bus", bus_addr | bus_wdata | 32'(bus_byteen), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid.no_done", 32'({m0_done, m1_done}), 32'd0);
    end
    bus_rdata = 32'h7777_0000;
    m0_addr = 32'h0000_0040; m0_wdata = 32'h0; m0_byteen = 4'h0; m0_req = 1'b1;
    m1_addr = 32'h0000_0044; m1_wdata = 32'h0; m1_byteen = 4'h0; m1_req = 1'b1;
    reset = 1'b1;
    push(1'b0, 1'b0, 32'h7777_0000, 32'h40, 32'h0, 4'h0);
    run_txn(3, 1'b1, "post_reset_m0");
    idle_check("post_reset_m0");

    // WAIT_CYCLES=3 instance: rdata is the value in the final WAIT cycle
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m0_addr = 32'h0000_0020; m0_wdata = 32'h0; m0_byteen = 4'h0; m0_req = 1'b1; m1_req = 1'b0;
    bus_rdata = 32'h1000_0000;
    push(1'b0, 1'b0, 32'h1000_0004, 32'h20, 32'h0, 4'h0);
    done_k = 0; done_rdata = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("w3.ack", 32'(m0_ack_w3), 32'd1);
        m0_req = 1'b0;
      end
      if (k == 3) begin
        chk("w1.done_k3", 32'(m0_done), 32'd1);
        chk("w1.rdata_k3", m0_rdata, 32'h1000_0002);
      end
      if (m0_done_w3 && done_k == 0) begin
        done_k = k;
        done_rdata = m0_rdata_w3;
        chk("w3.err", 32'(m0_err_w3), 32'd0);
      end
      bus_rdata = 32'h1000_0000 + 32'(k);
    end
    chk("w3.latency", 32'(done_k), 32'd5);
    if (exp_q.size() > 0) begin
      e3 = exp_q.pop_front();
      chk("w3.rdata", done_rdata, e3.rdata);
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bridge_bus_arbiter.md
Name: bridge_bus_arbiter

Overview:
- Two-master arbiter and sequencer in front of the system bridge.
- Master 0 is the CPU data port; master 1 is a DMA or debug master.
- Accepts one transaction at a time using round-robin priority, drives the bridge-side address, write data and byteen for a fixed access window, captures read data, and returns a one-cycle done/err response to the owning master.
- Rejects addresses outside the DM, TC0 and TC1 windows without touching the bus.

Parameters:
- WAIT_CYCLES, 1, cycles the address is held after the write/issue cycle before read data is captured (≥1).
- DM_START, 32'h0000_0000, DM window low bound.
- DM_END, 32'h0000_2FFF, DM window high bound (inclusive).
- TC0_START, 32'h0000_7F00, Timer0 window low bound.
- TC0_END, 32'h0000_7F0B, Timer0 window high bound (inclusive).
- TC1_START, 32'h0000_7F10, Timer1 window low bound.
- TC1_END, 32'h0000_7F1B, Timer1 window high bound (inclusive).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  request level, sampled only in IDLE
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_byteen / m1_byteen  in  4  byte enables; 0 means read
- m0_ack / m1_ack  out  1  one-cycle pulse in the ADDR cycle; the request is latched
- m0_done / m1_done  out  1  one-cycle pulse: response valid
- m0_err / m1_err  out  1  valid with done: access rejected
- m0_rdata / m1_rdata  out  32  read data, valid with done
- bus_addr  out  32  to the bridge address input
- bus_wdata  out  32  to the bridge write data
- bus_byteen  out  4  to the bridge byteen
- bus_rdata  in  32  bridge read mux output
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous) forces the following; reset mid-transaction aborts with no done pulse:
  - state=IDLE
  - all outputs 0
  - latched addr/wdata/byteen 0
  - last_grant=1, so m0 wins the first tie
- States: IDLE, ADDR, WAIT, RESP.
- IDLE, arbitration on the clock edge:
  - Only one master requesting: grant it.
  - Both requesting: grant the master ≠ last_grant.
  - On grant: update last_grant, latch that master's addr/wdata/byteen.
- Decode at accept time, on latched values:
  - Address inside the DM window: valid.
  - Address inside the TC0 or TC1 window with byteen ∈ {0000, 1111}: valid.
  - TC window with any other byteen: error.
  - Any other address: error.
  - Valid → ADDR. Error → RESP with err=1, rdata=0; the bus is never driven.
- ADDR (exactly 1 cycle):
  - bus_addr=latched addr, bus_wdata=latched wdata, bus_byteen=latched byteen.
  - The write commits at the end of this cycle.
  - ack of the owner = 1.
  - → WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - bus_addr and bus_wdata held; bus_byteen=0, so each write happens exactly once.
  - Counter decrements each cycle.
  - On the cycle with counter==0: capture bus_rdata into the rdata register, → RESP.
- RESP (1 cycle):
  - Owner's done=1; rdata valid (captured value, or 0 on error); err as decoded.
  - Non-owner's done/err/rdata = 0.
  - bus_* = 0.
  - → IDLE.
- Outside ADDR/WAIT: bus_addr=0, bus_wdata=0, bus_byteen=0.
- Latency for a valid access: done is asserted 2+WAIT_CYCLES cycles after the accept edge. Error latency is 1 cycle after the accept edge.
- Master req changes after the accept edge are ignored until the next IDLE.
- A req still high in IDLE after done is a new request and is arbitrated normally. Round-robin guarantees the other master is served first if it is waiting.
- Addresses are compared as 32-bit unsigned values; both window bounds are inclusive.
- No alignment check for DM; bus_addr passes through unmodified.
- rdata registers hold their value only during the done cycle and are 0 otherwise.

Test Plan:
- DM read, m0 only: m0 reads addr 0x0000_0010 with byteen 0, bus_rdata=0xDEADBEEF from ADDR onward.
  - ack in cycle 1, done=1 in cycle 3, m0_rdata=0xDEADBEEF, err=0.
  - bus_byteen=0 throughout.
- Simultaneous requests from reset: m0 and m1 both hold req with valid DM writes.
  - Order is m0, m1, m0, m1.
  - bus_byteen=1111 only in each ADDR cycle; busy drops for exactly 1 IDLE cycle between transactions.
- Partial-byte timer write: m1 writes addr 0x7F04 with byteen 0011.
  - m1_done=1, m1_err=1 one cycle after accept.
  - bus_byteen never nonzero; m1_rdata=0.
- Out-of-range read: m0 reads 0x0000_5000 → err=1, rdata=0, no bus activity.
  - The next m0 read of 0x7F14 succeeds with err=0.
- Reset mid-transaction: assert reset in the WAIT cycle of an m1 write.
  - All outputs go to 0 immediately; no done pulse.
  - After release with both reqs high, m0 is granted first.
- WAIT_CYCLES=3: m0 reads DM.
  - done arrives 5 cycles after accept.
  - rdata equals the bus_rdata sampled in the final WAIT cycle, not earlier values.
